// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO slice.
// Holds the default geometry (data/address width), the read-mode
// encodings used by the FWFT parameter, and the request-combination
// enum used when updating the occupancy count.
package fifo_pkg;

    // Default geometry: 4-bit words, 4-entry storage.
    localparam int DW_DEFAULT = 4;
    localparam int AW_DEFAULT = 2;

    // Read-mode encodings for the FWFT parameter.
    localparam int FWFT_STD = 0;  // registered read, one cycle after the request
    localparam int FWFT_ON  = 1;  // head word always presented on dat_o

    // Combination of accepted operations in one cycle, {write, read}.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: 2**AW words of DW bits.
// One synchronous write port and one asynchronous (combinational) read
// port. Contents are never reset.
//
// Ports:
//   clk_i  - clock, writes occur on its rising edge
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data, combinational from raddr
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input  logic          clk_i,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered status flags, sticky overflow and
// underflow indicators, and a selectable read mode (standard registered
// read or first-word-fall-through).
//
// Ports:
//   clk_i   - clock, all state updates on the rising edge
//   rst_i   - synchronous active-high reset
//   dat_i   - write data
//   wen     - write request (refused while full)
//   ren     - read request (refused while empty)
//   clr_err - clears the sticky ovf/udf flags
//   dat_o   - read data
//   full    - count == 2**AW
//   empty   - count == 0
//   afull   - count >= AFULL_TH
//   aempty  - count <= AEMPTY_TH
//   count   - number of stored words, 0..2**AW
//   ovf     - sticky: write attempted while full
//   udf     - sticky: read attempted while empty
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int DW        = DW_DEFAULT,
    parameter int AW        = AW_DEFAULT,
    parameter int AFULL_TH  = 3,
    parameter int AEMPTY_TH = 1,
    parameter int FWFT      = FWFT_STD
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [DW-1:0] dat_i,
    input  logic          wen,
    input  logic          ren,
    input  logic          clr_err,
    output logic [DW-1:0] dat_o,
    output logic          full,
    output logic          empty,
    output logic          afull,
    output logic          aempty,
    output logic [AW:0]   count,
    output logic          ovf,
    output logic          udf
);

    localparam logic [AW:0] DEPTH_C   = (AW+1)'(2**AW);
    localparam logic [AW:0] AFULL_C   = (AW+1)'(AFULL_TH);
    localparam logic [AW:0] AEMPTY_C  = (AW+1)'(AEMPTY_TH);
    localparam logic [AW:0] ONE_C     = (AW+1)'(1);

    // Pointers carry one extra wrap bit; only the low AW bits address memory.
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [AW:0]   rptr_next;
    logic [AW:0]   count_next;
    logic          wr_acc;
    logic          rd_acc;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] head_next;

    fifo_mem #(
        .DW (DW),
        .AW (AW)
    ) u_mem (
        .clk_i (clk_i),
        .we    (wr_acc),
        .waddr (wptr[AW-1:0]),
        .wdata (dat_i),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    always_comb begin
        wr_acc     = wen & ~full;
        rd_acc     = ren & ~empty;
        rptr_next  = rd_acc ? rptr + ONE_C : rptr;
        count_next = count;
        case (fifo_op_e'({wr_acc, rd_acc}))
            OP_WRITE: count_next = count + ONE_C;
            OP_READ:  count_next = count - ONE_C;
            default:  count_next = count;
        endcase
    end

    // Standard mode reads the word being popped; fall-through mode looks
    // ahead to the word that will be at the head after this edge.
    assign mem_raddr = (FWFT != 0) ? rptr_next[AW-1:0] : rptr[AW-1:0];

    // The new head may be the word written on this very edge (FIFO was
    // empty, or a one-deep remainder was just popped), which is not yet in
    // memory, so it is forwarded from dat_i.
    assign head_next = (wr_acc && (wptr[AW-1:0] == rptr_next[AW-1:0])) ? dat_i : mem_rdata;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            afull  <= 1'b0;
            aempty <= 1'b1;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + ONE_C;
            end
            rptr   <= rptr_next;
            count  <= count_next;
            full   <= (count_next == DEPTH_C);
            empty  <= (count_next == '0);
            afull  <= (count_next >= AFULL_C);
            aempty <= (count_next <= AEMPTY_C);
            // A new error event wins over a simultaneous clear.
            ovf    <= (wen & full)  | (ovf & ~clr_err);
            udf    <= (ren & empty) | (udf & ~clr_err);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dat_o <= '0;
        end else if (FWFT != 0) begin
            // Holds the last value once the FIFO drains.
            if (count_next != '0) begin
                dat_o <= head_next;
            end
        end else if (rd_acc) begin
            dat_o <= mem_rdata;
        end
    end

    // Pointer distance always equals the stored word count.
    assert property (@(posedge clk_i) disable iff (rst_i) ((wptr - rptr) == count));

endmodule
